// File: rtl/timerio.sv
// timerio: programmable interval timer slave in the cpu11 I/O window.
// An 8-bit prescaler feeds a 16-bit down-counter with auto-reload/one-shot, TF/irq and a square-wave pin.
module timerio #(
    parameter logic [7:0]  PRE_DEFAULT    = 8'd11,
    parameter logic [15:0] RELOAD_DEFAULT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    output logic       tmr_out
);

    typedef enum logic [2:0] {
        REG_CTRL = 3'd0,
        REG_STAT = 3'd1,
        REG_PRE  = 3'd2,
        REG_RLDH = 3'd3,
        REG_RLDL = 3'd4,
        REG_CNTH = 3'd5,
        REG_CNTL = 3'd6,
        REG_NONE = 3'd7
    } reg_sel_t;

    logic        r_en;
    logic        r_ie;
    logic        r_oneshot;
    logic        r_tf;
    logic [7:0]  r_pre;
    logic [7:0]  r_pcnt;
    logic [7:0]  r_stage;
    logic [15:0] r_reload;
    logic [15:0] r_cnt;
    logic [7:0]  r_shadow;
    logic        r_irq;
    logic        r_tmr;

    reg_sel_t    w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wr_pre;
    logic        w_wr_rldh;
    logic        w_wr_rldl;
    logic        w_rd_cnth;
    logic        w_tick;
    logic        w_underflow;
    logic        w_en_next;
    logic        w_ie_next;
    logic        w_tf_next;
    logic [15:0] w_load_val;

    assign w_sel     = reg_sel_t'(AD);
    assign w_wr      = cs & ~rw;
    assign w_rd      = cs & rw;
    assign w_wr_ctrl = w_wr && (w_sel == REG_CTRL);
    assign w_wr_stat = w_wr && (w_sel == REG_STAT);
    assign w_wr_pre  = w_wr && (w_sel == REG_PRE);
    assign w_wr_rldh = w_wr && (w_sel == REG_RLDH);
    assign w_wr_rldl = w_wr && (w_sel == REG_RLDL);
    assign w_rd_cnth = w_rd && (w_sel == REG_CNTH);

    assign w_load_val  = {r_stage, DI};
    assign w_tick      = r_en && (r_pcnt == r_pre);
    assign w_underflow = w_tick && (r_cnt == 16'd0);

    // A CPU write to CTRL overrides the one-shot auto-disable on the same edge.
    assign w_en_next = w_wr_ctrl ? DI[0] :
                       (w_underflow && r_oneshot) ? 1'b0 : r_en;
    assign w_ie_next = w_wr_ctrl ? DI[1] : r_ie;
    assign w_tf_next = w_underflow ? 1'b1 :
                       (w_wr_stat && DI[0]) ? 1'b0 : r_tf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_oneshot <= 1'b0;
        end else begin
            r_en <= w_en_next;
            r_ie <= w_ie_next;
            if (w_wr_ctrl) begin
                r_oneshot <= DI[2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tf  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_tf  <= w_tf_next;
            r_irq <= w_tf_next & w_ie_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre   <= PRE_DEFAULT;
            r_stage <= 8'h00;
        end else begin
            if (w_wr_pre) begin
                r_pre <= DI;
            end
            if (w_wr_rldh) begin
                r_stage <= DI;
            end
        end
    end

    // Prescaler restarts on PRE or RLD_L writes and idles at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt <= 8'h00;
        end else if (w_wr_pre || w_wr_rldl || !r_en) begin
            r_pcnt <= 8'h00;
        end else if (w_tick) begin
            r_pcnt <= 8'h00;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reload <= RELOAD_DEFAULT;
            r_cnt    <= RELOAD_DEFAULT;
        end else if (w_wr_rldl) begin
            r_reload <= w_load_val;
            r_cnt    <= w_load_val;
        end else if (w_tick) begin
            r_cnt <= (r_cnt == 16'd0) ? r_reload : (r_cnt - 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= 1'b0;
        end else if (w_underflow) begin
            r_tmr <= ~r_tmr;
        end
    end

    // Reading CNT_H freezes the low byte so a following CNT_L read cannot tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= 8'h00;
        end else if (w_rd_cnth) begin
            r_shadow <= r_cnt[7:0];
        end
    end

    always_comb begin
        DO = 8'h00;
        case (w_sel)
            REG_CTRL: DO = {5'b00000, r_oneshot, r_ie, r_en};
            REG_STAT: DO = {r_en, 6'b000000, r_tf};
            REG_PRE:  DO = r_pre;
            REG_RLDH: DO = r_stage;
            REG_CNTH: DO = r_cnt[15:8];
            REG_CNTL: DO = r_shadow;
            default:  DO = 8'h00;
        endcase
    end

    assign irq     = r_irq;
    assign tmr_out = r_tmr;

endmodule

// File: tb/tb_timerio.sv
// tb_timerio: scoreboard bench for timerio; expectations are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_timerio;

    logic       clk;
    logic       rst;
    logic [2:0] AD;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       rw;
    logic       cs;
    logic       irq;
    logic       tmr_out;

    int          nVectors = 0;
    int          nErrors  = 0;
    logic [15:0] expQ[$];
    string       nameQ[$];

    timerio dut (
        .clk     (clk),
        .rst     (rst),
        .AD      (AD),
        .DI      (DI),
        .DO      (DO),
        .rw      (rw),
        .cs      (cs),
        .irq     (irq),
        .tmr_out (tmr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bus tasks are entered 1ns after a rising edge and return 1ns after the next one.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        AD = a; DI = d; rw = 1'b0; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        AD = a; rw = 1'b1; cs = 1'b1;
        #1 d = DO;
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0]  resetTable [8];
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        resetTable = '{8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            expQ.push_back({8'h00, resetTable[a]});
            nameQ.push_back($sformatf("reset_do_ad%0d", a));
        end
        expQ.push_back(16'h0000); nameQ.push_back("reset_irq");
        expQ.push_back(16'h0000); nameQ.push_back("reset_tmr_out");
        for (int a = 0; a < 8; a++) begin
            AD = 3'(a);
            #1 got = {8'h00, DO};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
        for (int i = 0; i < 2; i++) begin
            got = (i == 0) ? {15'd0, irq} : {15'd0, tmr_out};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
    endtask

    task automatic test_periodic();
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        @(posedge clk); #1;
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h03);
        bus_write(3'd0, 8'h03);
        // Underflow every 4th edge after enable: TF/irq set at edge 4, tmr_out toggles at 4, 8.
        for (int k = 1; k <= 10; k++) begin
            expQ.push_back({13'd0, (k >= 4), (k >= 4), ((k / 4) % 2 == 1)});
            nameQ.push_back($sformatf("periodic_tf_irq_tmr_k%0d", k));
            @(posedge clk); #1;
            AD = 3'd1;
            #1 got = {13'd0, DO[0], irq, tmr_out};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
        bus_write(3'd0, 8'h02);
        expQ.push_back(16'h0003); nameQ.push_back("periodic_irq_held");
        AD = 3'd1;
        #1 got = {14'd0, DO[0], irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        bus_write(3'd1, 8'h01);
        expQ.push_back(16'h0000); nameQ.push_back("periodic_w1c_irq_low");
        AD = 3'd1;
        #1 got = {14'd0, DO[0], irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        bus_write(3'd0, 8'h00);
    endtask

    task automatic test_oneshot();
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        logic [7:0]  rd;
        @(posedge clk); #1;
        bus_write(3'd2, 8'h01);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h02);
        bus_write(3'd0, 8'h07);
        // Tick every 2 clk, count 2->1->0->underflow: single underflow on edge 6, EN drops.
        for (int k = 1; k <= 8; k++) begin
            expQ.push_back({6'd0, (k < 6), 6'b000000, (k >= 6), (k >= 6), (k >= 6)});
            nameQ.push_back($sformatf("oneshot_stat_irq_tmr_k%0d", k));
            @(posedge clk); #1;
            AD = 3'd1;
            #1 got = {6'd0, DO, irq, tmr_out};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
        expQ.push_back(16'h0006); nameQ.push_back("oneshot_ctrl_en_clear");
        expQ.push_back(16'h0000); nameQ.push_back("oneshot_cnt_h");
        expQ.push_back(16'h0002); nameQ.push_back("oneshot_cnt_l");
        for (int i = 0; i < 3; i++) begin
            bus_read((i == 0) ? 3'd0 : (i == 1) ? 3'd5 : 3'd6, rd);
            got = {8'h00, rd};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
        bus_write(3'd1, 8'h01);
        bus_write(3'd0, 8'h00);
    endtask

    task automatic test_atomic_read();
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          n;
        @(posedge clk); #1;
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h01);
        bus_write(3'd4, 8'h00);
        bus_write(3'd0, 8'h01);
        // n = cycles since enable; the count seen during cycle n is 0x0100 - n.
        n = 0;
        expQ.push_back(16'h0100 - 16'(n)); nameQ.push_back("atomic_pair_borrow");
        bus_read(3'd5, hi);
        bus_read(3'd6, lo);
        n += 2;
        got = {hi, lo};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        repeat (3) @(posedge clk);
        #1 n += 3;
        expQ.push_back(16'h0100 - 16'(n)); nameQ.push_back("atomic_pair_mid");
        expQ.push_back({8'h00, 8'(16'h0100 - 16'(n))}); nameQ.push_back("atomic_stale_shadow");
        bus_read(3'd5, hi);
        bus_read(3'd6, lo);
        got = {hi, lo};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        bus_read(3'd6, lo);
        got = {8'h00, lo};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        bus_write(3'd0, 8'h00);
    endtask

    task automatic test_collision();
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        @(posedge clk); #1;
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h00);
        bus_write(3'd4, 8'h03);
        bus_write(3'd0, 8'h03);
        repeat (7) @(posedge clk);
        #1;
        expQ.push_back(16'h0003); nameQ.push_back("collision_tf_before");
        AD = 3'd1;
        #1 got = {14'd0, DO[0], irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        // This W1C commits on edge 8, which is also an underflow edge: set must win.
        expQ.push_back(16'h0003); nameQ.push_back("collision_set_wins");
        bus_write(3'd1, 8'h01);
        AD = 3'd1;
        #1 got = {14'd0, DO[0], irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] got;
        logic [15:0] expV;
        string       expN;
        logic [2:0]  addrList [4];
        addrList = '{3'd0, 3'd1, 3'd2, 3'd5};
        @(posedge clk); #2;
        expQ.push_back(16'h0001); nameQ.push_back("async_irq_before");
        got = {15'd0, irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        #1 rst = 1'b0;
        expQ.push_back(16'h0000); nameQ.push_back("async_irq_tmr");
        expQ.push_back(16'h0000); nameQ.push_back("async_ctrl");
        expQ.push_back(16'h0000); nameQ.push_back("async_stat");
        expQ.push_back(16'h000B); nameQ.push_back("async_pre");
        expQ.push_back(16'h00FF); nameQ.push_back("async_cnt_h");
        #1 got = {14'd0, irq, tmr_out};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
        for (int i = 0; i < 4; i++) begin
            AD = addrList[i];
            #1 got = {8'h00, DO};
            expV = expQ.pop_front(); expN = nameQ.pop_front();
            nVectors++;
            if (got !== expV) begin
                nErrors++;
                $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        expQ.push_back(16'h0000); nameQ.push_back("async_after_ctrl_irq");
        @(posedge clk); #1;
        AD = 3'd0;
        #1 got = {7'd0, DO, irq};
        expV = expQ.pop_front(); expN = nameQ.pop_front();
        nVectors++;
        if (got !== expV) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h", expN, got, expV);
        end
    endtask

    initial begin
        cs  = 1'b0;
        rw  = 1'b1;
        AD  = 3'd0;
        DI  = 8'h00;
        rst = 1'b0;
        #22 rst = 1'b1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_atomic_read();
        test_collision();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
        $finish;
    end

endmodule
